interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer_pkg.sv | 24 ++
 rtl/tick_down_counter.sv | 28 ++
 rtl/interval_timer.sv | 97 +++++++++
 tb/tb_interval_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer and its counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interval_timer_pkg;

  // Controller states: wait for a start, give the parameter block an edge,
  // load the duration, then count seconds down.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2,
    COUNT = 2'd3
  } state_t;

  // Interval codes understood by the time-parameter block.
  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_DBL  = 2'b11;

  // Edges the time-parameter block needs to turn `interval` into `value`.
  localparam int PARAM_LAT = 1;

endpackage

// File: rtl/tick_down_counter.sv
// 4-bit loadable down-counter with a terminal (count==1) detect.
// Latency: load and decrement take effect at the next clk edge.
// Backpressure: none; saturates at 0 instead of wrapping.
module tick_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       at_one
);

  // Load has priority over decrement; a decrement at 0 is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  // Next decrement is the terminal one.
  assign at_one = (count == 4'd1);

endmodule

// File: rtl/interval_timer.sv
// Interval timer: fetches a duration for the requested code and counts it down in seconds.
// Latency: start at edge k loads the count at edge k+2; expired pulses the clk after the last tick.
// Backpressure: none; a new start always restarts, outputs are single-cycle pulses/levels.
module interval_timer
  import interval_timer_pkg::*;
(
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       oneHz_enable,
  input  logic       Start_Timer,
  input  logic [1:0] interval_req,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] interval_d;
  logic       expired_d;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_at_one;

  tick_down_counter u_cnt (
    .clk      (clk),
    .rst      (Reset_Sync),
    .load     (cnt_load),
    .load_val (value),
    .dec      (cnt_dec),
    .count    (remaining),
    .at_one   (cnt_at_one)
  );

  // Next-state logic: a start pre-empts everything, including a terminal tick.
  always_comb begin
    state_d    = state_q;
    interval_d = interval;
    expired_d  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (Start_Timer) begin
      state_d    = REQ;
      interval_d = interval_req;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        REQ: begin
          // Parameter block registers `value` on this edge.
          state_d = FETCH;
        end
        FETCH: begin
          cnt_load = 1'b1;
          if (value == 4'd0) begin
            // Zero-length interval ends immediately.
            expired_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (oneHz_enable) begin
            cnt_dec = 1'b1;
            if (cnt_at_one) begin
              expired_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q  <= IDLE;
      interval <= INT_BASE;
      expired  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      interval <= interval_d;
      expired  <= expired_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer with a registered time-parameter model.
// Expected expiries are queued by the stimulus and matched by a negedge monitor.
// Level checks on remaining/busy/interval are made between stimulus cycles.
module tb_interval_timer;
  import interval_timer_pkg::*;

  logic       clk = 1'b0;
  logic       Reset_Sync;
  logic       oneHz_enable;
  logic       Start_Timer;
  logic [1:0] interval_req;
  logic [3:0] value;
  logic [1:0] interval;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         at_cyc;
    logic [1:0] code;
  } exp_t;
  exp_t sb[$];

  interval_timer dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .oneHz_enable (oneHz_enable),
    .Start_Timer  (Start_Timer),
    .interval_req (interval_req),
    .value        (value),
    .interval     (interval),
    .expired      (expired),
    .busy         (busy),
    .remaining    (remaining)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Time-parameter block: fixed durations, registered one edge after interval.
  function automatic logic [3:0] vtab(input logic [1:0] c);
    case (c)
      INT_BASE: vtab = 4'd6;
      INT_EXT:  vtab = 4'd3;
      INT_YEL:  vtab = 4'd0;
      default:  vtab = 4'd4;
    endcase
  endfunction

  always @(posedge clk) value <= vtab(interval);

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_expiry(input int at_cyc, input logic [1:0] code);
    exp_t e;
    e.at_cyc = at_cyc;
    e.code   = code;
    sb.push_back(e);
  endtask

  // Called at a negedge: drive inputs for the next rising edge, return at the following negedge.
  task automatic drive(input logic st, input logic [1:0] code, input logic tk);
    Start_Timer  = st;
    interval_req = code;
    oneHz_enable = tk;
    @(negedge clk);
  endtask

  // Monitor: every expired pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (expired === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_expired_cycle", cyc, -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("expiry_cycle", cyc, e.at_cyc);
        chk("expiry_interval", int'(interval), int'(e.code));
        chk("expiry_remaining", int'(remaining), 0);
        chk("expiry_busy", int'(busy), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    Reset_Sync   = 1'b1;
    Start_Timer  = 1'b0;
    interval_req = 2'b00;
    oneHz_enable = 1'b0;
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b1);
    chk("rst_interval", int'(interval), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_busy", int'(busy), 0);
    Reset_Sync = 1'b0;
    drive(1'b0, 2'b00, 1'b0);

    // Basic 6-second interval, ticks offered in REQ and FETCH are ignored.
    drive(1'b1, INT_BASE, 1'b0);
    chk("basic_busy_req", int'(busy), 1);
    chk("basic_interval", int'(interval), 0);
    drive(1'b0, 2'b00, 1'b1);
    chk("basic_busy_fetch", int'(busy), 1);
    drive(1'b0, 2'b00, 1'b1);
    chk("basic_loaded", int'(remaining), 6);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      chk("basic_dec", int'(remaining), 6 - i);
      drive(1'b0, 2'b00, 1'b0);
    end
    expect_expiry(cyc + 1, INT_BASE);
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b0, 2'b00, 1'b0);
    chk("basic_pulse_width", int'(expired), 0);
    chk("basic_hold_zero", int'(remaining), 0);
    drive(1'b0, 2'b00, 1'b1);
    chk("basic_idle_tick", int'(remaining), 0);

    // Zero duration: expiry straight after FETCH, no tick required.
    drive(1'b1, INT_YEL, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    expect_expiry(cyc + 1, INT_YEL);
    drive(1'b0, 2'b00, 1'b0);
    chk("zero_remaining", int'(remaining), 0);
    drive(1'b0, 2'b00, 1'b0);
    chk("zero_busy", int'(busy), 0);
    chk("zero_pulse_width", int'(expired), 0);

    // Restart during COUNT at remaining=3 with the EXT code.
    drive(1'b1, INT_BASE, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b1);
    chk("restart_pre", int'(remaining), 3);
    drive(1'b1, INT_EXT, 1'b0);
    chk("restart_interval", int'(interval), 1);
    chk("restart_busy", int'(busy), 1);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    chk("restart_reload", int'(remaining), 3);
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b0, 2'b00, 1'b1);
    chk("restart_dec", int'(remaining), 1);
    expect_expiry(cyc + 1, INT_EXT);
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b0, 2'b00, 1'b0);

    // Start coinciding with the terminal tick: start wins.
    drive(1'b1, INT_DBL, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    chk("sim_loaded", int'(remaining), 4);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b1);
    chk("sim_pre", int'(remaining), 1);
    drive(1'b1, INT_BASE, 1'b1);
    chk("sim_no_expired", int'(expired), 0);
    chk("sim_busy", int'(busy), 1);
    chk("sim_interval", int'(interval), 0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    chk("sim_reload", int'(remaining), 6);

    // Reset mid-count overrides a coincident start and tick.
    drive(1'b1, INT_DBL, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    chk("rmid_loaded", int'(remaining), 4);
    Reset_Sync = 1'b1;
    drive(1'b1, INT_EXT, 1'b1);
    Reset_Sync = 1'b0;
    chk("rmid_interval", int'(interval), 0);
    chk("rmid_remaining", int'(remaining), 0);
    chk("rmid_busy", int'(busy), 0);
    chk("rmid_expired", int'(expired), 0);
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b00, 1'b1);
    drive(1'b0, 2'b00, 1'b0);
    chk("rmid_idle_busy", int'(busy), 0);
    chk("rmid_idle_remaining", int'(remaining), 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
